// File: rtl/shared_ram_arb_if.sv
// Bus bundle between the two CPU-side requesters, the shared RAM and the arbiter.
// slave = arbiter view, master = requester/RAM view.
interface shared_ram_arb_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic [DW-1:0] a_dout;
    logic          a_ack;
    logic          a_wait_n;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din;
    logic [DW-1:0] b_dout;
    logic          b_ack;
    logic          b_wait_n;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    modport slave (
        input  a_req, a_we, a_addr, a_din,
        output a_dout, a_ack, a_wait_n,
        input  b_req, b_we, b_addr, b_din,
        output b_dout, b_ack, b_wait_n,
        output ram_addr, ram_din, ram_we,
        input  ram_q
    );

    modport master (
        output a_req, a_we, a_addr, a_din,
        input  a_dout, a_ack, a_wait_n,
        output b_req, b_we, b_addr, b_din,
        input  b_dout, b_ack, b_wait_n,
        input  ram_addr, ram_din, ram_we,
        output ram_q
    );
endinterface

// File: rtl/shared_ram_arb.sv
// Two-port arbiter for one single-port synchronous RAM shared by two Z80-class CPUs.
// Define SHRAM_ARB_FIXED_PRIO_EN to make port A win every tie instead of round-robin.
module shared_ram_arb #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic               clk_sys,
    input  logic               reset,
    shared_ram_arb_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACC_A  = 3'd1,
        S_ACC_B  = 3'd2,
        S_DONE_A = 3'd3,
        S_DONE_B = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_pend_a;
    logic          w_pend_b;
    logic          r_served_a;
    logic          r_served_b;
    logic          r_ack_a;
    logic          r_ack_b;
    logic          r_acc_wr;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;
    logic [DW-1:0] r_dout_a;
    logic [DW-1:0] r_dout_b;
`ifndef SHRAM_ARB_FIXED_PRIO_EN
    logic          r_last_b;
`endif

    // The ack cycle already counts as served so wait_n releases with the ack.
    assign w_pend_a = bus.a_req & ~r_served_a & ~r_ack_a;
    assign w_pend_b = bus.b_req & ~r_served_b & ~r_ack_b;

    // FSM state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and grant decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pend_a && w_pend_b) begin
`ifdef SHRAM_ARB_FIXED_PRIO_EN
                    w_grant_a = 1'b1;
                    w_grant_b = 1'b0;
`else
                    w_grant_a = r_last_b;
                    w_grant_b = ~r_last_b;
`endif
                end else begin
                    w_grant_a = w_pend_a;
                    w_grant_b = w_pend_b;
                end
                if (w_grant_a) begin
                    w_state_nxt = S_ACC_A;
                end else if (w_grant_b) begin
                    w_state_nxt = S_ACC_B;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACC_A:  w_state_nxt = S_DONE_A;
            S_ACC_B:  w_state_nxt = S_DONE_B;
            S_DONE_A: w_state_nxt = S_IDLE;
            S_DONE_B: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Served flags: block re-service of a request held high past its ack
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_served_a <= 1'b0;
            r_served_b <= 1'b0;
        end else begin
            if (!bus.a_req) begin
                r_served_a <= 1'b0;
            end else if (r_ack_a) begin
                r_served_a <= 1'b1;
            end
            if (!bus.b_req) begin
                r_served_b <= 1'b0;
            end else if (r_ack_b) begin
                r_served_b <= 1'b1;
            end
        end
    end

`ifndef SHRAM_ARB_FIXED_PRIO_EN
    // Round-robin memory; B at reset so A wins the first tie
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_last_b <= 1'b1;
        end else if (w_grant_a) begin
            r_last_b <= 1'b0;
        end else if (w_grant_b) begin
            r_last_b <= 1'b1;
        end
    end
`endif

    // RAM command capture, ack pulse and read-data return
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ram_addr <= {AW{1'b0}};
            r_ram_din  <= {DW{1'b0}};
            r_ram_we   <= 1'b0;
            r_acc_wr   <= 1'b0;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_dout_a   <= {DW{1'b0}};
            r_dout_b   <= {DW{1'b0}};
        end else begin
            r_ack_a <= (r_state == S_ACC_A);
            r_ack_b <= (r_state == S_ACC_B);
            if (w_grant_a) begin
                r_ram_addr <= bus.a_addr;
                r_ram_din  <= bus.a_din;
                r_ram_we   <= bus.a_we;
                r_acc_wr   <= bus.a_we;
            end else if (w_grant_b) begin
                r_ram_addr <= bus.b_addr;
                r_ram_din  <= bus.b_din;
                r_ram_we   <= bus.b_we;
                r_acc_wr   <= bus.b_we;
            end else begin
                r_ram_we   <= 1'b0;
            end
            if ((r_state == S_DONE_A) && !r_acc_wr) begin
                r_dout_a <= bus.ram_q;
            end
            if ((r_state == S_DONE_B) && !r_acc_wr) begin
                r_dout_b <= bus.ram_q;
            end
        end
    end

    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_din  = r_ram_din;
    assign bus.ram_we   = r_ram_we;
    assign bus.a_dout   = r_dout_a;
    assign bus.b_dout   = r_dout_b;
    assign bus.a_ack    = r_ack_a;
    assign bus.b_ack    = r_ack_b;
    assign bus.a_wait_n = ~w_pend_a;
    assign bus.b_wait_n = ~w_pend_b;
endmodule

// File: tb/tb_shared_ram_arb.sv
// Randomised self-checking bench for shared_ram_arb with a transaction-level model
// (service order, ack latency, shadow memory) and a behavioural synchronous RAM.
module tb_shared_ram_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shared_ram_arb_if #(.AW(11), .DW(8)) bus ();

    shared_ram_arb #(.AW(11), .DW(8)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus.slave)
    );

    logic [7:0]  mem     [0:2047];
    logic [7:0]  ref_mem [0:2047];
    logic        tb_load;
    logic [10:0] ld_addr;
    logic [7:0]  ld_data;

    // Synchronous RAM: read data one cycle after the address
    always @(posedge clk) begin
        if (tb_load) begin
            mem[ld_addr] <= ld_data;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        bus.ram_q <= mem[bus.ram_addr];
    end

    int   n_total = 0;
    int   n_bad   = 0;
    logic [7:0] ref_a_dout = 8'h00;
    logic [7:0] ref_b_dout = 8'h00;
    bit   ref_last_b = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_port(input bit is_a, input bit we, input logic [10:0] ad, input logic [7:0] d);
        if (we) ref_mem[ad] = d;
        else if (is_a) ref_a_dout = ref_mem[ad];
        else ref_b_dout = ref_mem[ad];
    endtask

    // One request on A and/or B raised together; the model predicts order and timing.
    task automatic do_pair(input bit ra, input bit rb, input bit wa, input bit wb,
                           input logic [10:0] aa, input logic [10:0] ab,
                           input logic [7:0] da, input logic [7:0] db);
        int ka, kb, na, nb, nwe, exp_ka, exp_kb;
        bit a_first;
`ifdef SHRAM_ARB_FIXED_PRIO_EN
        a_first = ra;
`else
        a_first = ra & (~rb | ref_last_b);
`endif
        exp_ka = ra ? (a_first ? 2 : 5) : -1;
        exp_kb = rb ? ((ra && a_first) ? 5 : 2) : -1;
        bus.a_req = ra; bus.a_we = wa; bus.a_addr = aa; bus.a_din = da;
        bus.b_req = rb; bus.b_we = wb; bus.b_addr = ab; bus.b_din = db;
        ka = -1; kb = -1; na = 0; nb = 0; nwe = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (bus.a_ack) begin na++; ka = k; end
            if (bus.b_ack) begin nb++; kb = k; end
            if (bus.ram_we) begin
                nwe++;
                if (ra && exp_ka == k + 1) begin
                    check_eq("wr_addr_a", bus.ram_addr, aa);
                    check_eq("wr_din_a", bus.ram_din, da);
                end else if (rb && exp_kb == k + 1) begin
                    check_eq("wr_addr_b", bus.ram_addr, ab);
                    check_eq("wr_din_b", bus.ram_din, db);
                end else begin
                    check_eq("wr_unexpected", 32'd1, 32'd0);
                end
            end
            if (bus.a_req) check_eq("a_wait_n", bus.a_wait_n, (k < exp_ka) ? 32'd0 : 32'd1);
            else           check_eq("a_wait_n_idle", bus.a_wait_n, 32'd1);
            if (bus.b_req) check_eq("b_wait_n", bus.b_wait_n, (k < exp_kb) ? 32'd0 : 32'd1);
            else           check_eq("b_wait_n_idle", bus.b_wait_n, 32'd1);
            if (bus.a_ack) begin
                bus.a_req = 1'b0; bus.a_addr = 11'($urandom); bus.a_din = 8'($urandom);
            end
            if (bus.b_ack) begin
                bus.b_req = 1'b0; bus.b_addr = 11'($urandom); bus.b_din = 8'($urandom);
            end
        end
        check_eq("a_ack_cycle", ka, exp_ka);
        check_eq("b_ack_cycle", kb, exp_kb);
        check_eq("a_ack_count", na, {31'd0, ra});
        check_eq("b_ack_count", nb, {31'd0, rb});
        check_eq("we_count", nwe, (ra && wa ? 1 : 0) + (rb && wb ? 1 : 0));
        if (a_first) begin
            if (ra) apply_port(1'b1, wa, aa, da);
            if (rb) apply_port(1'b0, wb, ab, db);
        end else begin
            if (rb) apply_port(1'b0, wb, ab, db);
            if (ra) apply_port(1'b1, wa, aa, da);
        end
        ref_last_b = (ra && rb) ? a_first : rb;
        check_eq("a_dout", bus.a_dout, ref_a_dout);
        check_eq("b_dout", bus.b_dout, ref_b_dout);
        if (ra && wa) check_eq("mem_a", mem[aa], ref_mem[aa]);
        if (rb && wb) check_eq("mem_b", mem[ab], ref_mem[ab]);
    endtask

    initial begin
        int ka, na, nwe, sel;
        rst = 1'b1; tb_load = 1'b0; ld_addr = 11'd0; ld_data = 8'd0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 11'd0; bus.a_din = 8'd0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 11'd0; bus.b_din = 8'd0;
        #2;
        check_eq("rst_ram_we", bus.ram_we, 32'd0);
        check_eq("rst_ram_addr", bus.ram_addr, 32'd0);
        check_eq("rst_ram_din", bus.ram_din, 32'd0);
        check_eq("rst_a_dout", bus.a_dout, 32'd0);
        check_eq("rst_b_dout", bus.b_dout, 32'd0);
        check_eq("rst_a_ack", bus.a_ack, 32'd0);
        check_eq("rst_b_ack", bus.b_ack, 32'd0);
        check_eq("rst_a_wait_n", bus.a_wait_n, 32'd1);

        tb_load = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            ld_addr = 11'(i);
            ld_data = (i == 32'h123) ? 8'h5A : 8'($urandom);
            ref_mem[i] = ld_data;
            @(posedge clk); #1;
        end
        tb_load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // single read, single write, then two rounds of contention
        do_pair(1'b1, 1'b0, 1'b0, 1'b0, 11'h123, 11'h000, 8'h00, 8'h00);
        check_eq("read_5a", bus.a_dout, 32'h5A);
        do_pair(1'b0, 1'b1, 1'b0, 1'b1, 11'h000, 11'h7FF, 8'h00, 8'hC3);
        check_eq("write_b_dout_kept", bus.b_dout, 32'h00);
        do_pair(1'b1, 1'b1, 1'b0, 1'b1, 11'h123, 11'h100, 8'h00, 8'h77);
        do_pair(1'b1, 1'b1, 1'b1, 1'b0, 11'h300, 11'h7FF, 8'h99, 8'h00);

        // request held high past its ack is not re-serviced
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h123;
        ka = -1; na = 0; nwe = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus.a_ack) begin na++; if (ka < 0) ka = k; end
            if (bus.ram_we) nwe++;
        end
        ref_a_dout = ref_mem[11'h123]; ref_last_b = 1'b0;
        check_eq("held_ack_cycle", ka, 32'd2);
        check_eq("held_ack_count", na, 32'd1);
        check_eq("held_we_count", nwe, 32'd0);
        check_eq("held_wait_n", bus.a_wait_n, 32'd1);
        check_eq("held_dout", bus.a_dout, ref_a_dout);
        bus.a_req = 1'b0;
        @(posedge clk); #1;
        bus.a_req = 1'b1; bus.a_addr = 11'h010;
        ka = -1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (bus.a_ack) begin ka = k; bus.a_req = 1'b0; end
        end
        ref_a_dout = ref_mem[11'h010];
        check_eq("rearm_ack_cycle", ka, 32'd2);
        check_eq("rearm_dout", bus.a_dout, ref_a_dout);

        // request dropped mid-access still completes
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 11'h200;
        @(posedge clk); #1;
        bus.b_req = 1'b0; bus.b_addr = 11'h3FF;
        @(posedge clk); #1;
        check_eq("drop_ack", bus.b_ack, 32'd1);
        ref_b_dout = ref_mem[11'h200]; ref_last_b = 1'b1;
        @(posedge clk); #1;
        check_eq("drop_ack_end", bus.b_ack, 32'd0);
        check_eq("drop_dout", bus.b_dout, ref_b_dout);
        do_pair(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h201, 8'h00, 8'h00);

        // reset during the write cycle of B
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 11'h055; bus.b_din = 8'hEE;
        @(posedge clk); #1;
        check_eq("rst_mid_we_pre", bus.ram_we, 32'd1);
        rst = 1'b1; bus.b_req = 1'b0;
        #1;
        check_eq("rst_mid_we", bus.ram_we, 32'd0);
        check_eq("rst_mid_addr", bus.ram_addr, 32'd0);
        check_eq("rst_mid_din", bus.ram_din, 32'd0);
        check_eq("rst_mid_a_dout", bus.a_dout, 32'd0);
        check_eq("rst_mid_b_dout", bus.b_dout, 32'd0);
        ref_a_dout = 8'h00; ref_b_dout = 8'h00; ref_last_b = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check_eq("rst_mid_no_ack", bus.b_ack, 32'd0);
        end
        rst = 1'b0;
        check_eq("rst_mid_nowrite", mem[11'h055], ref_mem[11'h055]);
        do_pair(1'b0, 1'b1, 1'b0, 1'b1, 11'h000, 11'h055, 8'h00, 8'hEE);

        // randomised mix over a small address pool to provoke collisions
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(1, 3);
            do_pair(sel[0], sel[1], 1'($urandom), 1'($urandom),
                    11'($urandom_range(0, 15)), 11'($urandom_range(0, 15)),
                    8'($urandom), 8'($urandom));
        end
        for (int t = 0; t < 4; t++) begin
            do_pair(1'b1, 1'b1, 1'($urandom), 1'($urandom),
                    11'($urandom_range(0, 15)), 11'($urandom_range(0, 15)),
                    8'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
